tt_design_selector: RTL



---
 rtl/tt_design_selector.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/tt_design_selector.sv
// ---------------------------------------------------------------------------
// tt_design_selector
//
// Purpose:
//   Control stage in front of tt_top. Synchronises the raw Caravel pad
//   controls, keeps the index of the selected user design and sequences every
//   selection change through a reset-then-enable cycle of that design.
//
// Optional feature (compile-time macro): TT_SEL_DEBOUNCE_EN
//   When defined, pad_sel_inc, pad_sel_rst_n and pad_load_latch are debounced
//   after synchronisation (DEBOUNCE_CYCLES stable clocks). When undefined,
//   no debounce logic is built.
//
// Ports:
//   wb_clk_i        in   system clock (the only clock)
//   wb_rst_i        in   synchronous active-high reset
//   pad_sel_rst_n   in   async pad, active-low level: force address to 0
//   pad_sel_inc     in   async pad, rising edge: address + 1 (wraps)
//   pad_ena         in   async pad, level: enable request for selected design
//   pad_load_clk    in   async pad, rising edge: shift pad_load_dat in at MSB
//   pad_load_dat    in   async pad, serial address bit (LSB first)
//   pad_load_latch  in   async pad, rising edge: commit shift register
//   sel_addr        out  selected design address
//   sel_ena         out  selected design enabled
//   design_rst_n    out  active-low reset to the selected design
//   busy            out  high while the design is held in reset (DRST)
//   load_err        out  sticky: a latched value was out of range
// ---------------------------------------------------------------------------
module tt_design_selector #(
   parameter int ADDR_W          = 9,
   parameter int NUM_DESIGNS     = 250,
   parameter int SYNC_STAGES     = 2,
   parameter int RST_CYCLES      = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              pad_sel_rst_n,
   input  logic              pad_sel_inc,
   input  logic              pad_ena,
   input  logic              pad_load_clk,
   input  logic              pad_load_dat,
   input  logic              pad_load_latch,
   output logic [ADDR_W-1:0] sel_addr,
   output logic              sel_ena,
   output logic              design_rst_n,
   output logic              busy,
   output logic              load_err
);

   // Bit positions of the pads inside the packed pad vector.
   localparam int NPAD    = 6;
   localparam int P_SRST  = 0;
   localparam int P_INC   = 1;
   localparam int P_ENA   = 2;
   localparam int P_LCLK  = 3;
   localparam int P_LDAT  = 4;
   localparam int P_LATCH = 5;

   // Inactive level of every pad: only pad_sel_rst_n idles high.
   localparam logic [NPAD-1:0] PAD_IDLE = 6'b000001;

   localparam int                CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RST_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_DESIGNS - 1);
   localparam logic [ADDR_W:0]   NUM_EXT   = (ADDR_W + 1)'(NUM_DESIGNS);

   typedef enum logic {DRST, ACTIVE} state_t;

   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
      if (a >= ADDR_LAST) return '0;
      return a + 1'b1;
   endfunction

   logic [NPAD-1:0] pads;
   assign pads = {pad_load_latch, pad_load_dat, pad_load_clk,
                  pad_ena, pad_sel_inc, pad_sel_rst_n};

   // ---- stage p0: pad synchronisers --------------------------------------
   logic [SYNC_STAGES-1:0][NPAD-1:0] sync_p0;
   logic [NPAD-1:0]                  sync_lvl;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) sync_p0 <= {SYNC_STAGES{PAD_IDLE}};
      else          sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pads};
   end

   assign sync_lvl = sync_p0[SYNC_STAGES-1];

   logic [NPAD-1:0] lvl;

`ifdef TT_SEL_DEBOUNCE_EN
   localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // Debounced pads: [0]=sel_rst_n, [1]=sel_inc, [2]=load_latch.
   logic [2:0]      db_in;
   logic [2:0]      db_lvl;
   logic [DB_W-1:0] db_cnt [3];

   assign db_in = {sync_lvl[P_LATCH], sync_lvl[P_INC], sync_lvl[P_SRST]};

   // Level follows the input only after it has differed for DEBOUNCE_CYCLES
   // consecutive clocks; any return to the current level restarts the count.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         db_lvl <= 3'b001;
         for (int j = 0; j < 3; j++) db_cnt[j] <= '0;
      end else begin
         for (int j = 0; j < 3; j++) begin
            if (db_in[j] == db_lvl[j]) begin
               db_cnt[j] <= '0;
            end else if (db_cnt[j] == DB_LAST) begin
               db_lvl[j] <= db_in[j];
               db_cnt[j] <= '0;
            end else begin
               db_cnt[j] <= db_cnt[j] + 1'b1;
            end
         end
      end
   end

   assign lvl = {db_lvl[2], sync_lvl[P_LDAT], sync_lvl[P_LCLK],
                 sync_lvl[P_ENA], db_lvl[1], db_lvl[0]};
`else
   assign lvl = sync_lvl;
`endif

   // ---- stage p1: edge detection, registered events ----------------------
   logic prev_inc_p1, prev_lclk_p1, prev_latch_p1;
   logic rst_ev_p1, inc_ev_p1, shift_ev_p1, latch_ev_p1, dat_p1;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         prev_inc_p1   <= 1'b0;
         prev_lclk_p1  <= 1'b0;
         prev_latch_p1 <= 1'b0;
         rst_ev_p1     <= 1'b0;
         inc_ev_p1     <= 1'b0;
         shift_ev_p1   <= 1'b0;
         latch_ev_p1   <= 1'b0;
         dat_p1        <= 1'b0;
      end else begin
         prev_inc_p1   <= lvl[P_INC];
         prev_lclk_p1  <= lvl[P_LCLK];
         prev_latch_p1 <= lvl[P_LATCH];
         rst_ev_p1     <= ~lvl[P_SRST];
         inc_ev_p1     <= lvl[P_INC]   & ~prev_inc_p1;
         shift_ev_p1   <= lvl[P_LCLK]  & ~prev_lclk_p1;
         latch_ev_p1   <= lvl[P_LATCH] & ~prev_latch_p1;
         dat_p1        <= lvl[P_LDAT];
      end
   end

   // ---- stage p2: address selection and reset/enable sequencing ----------
   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] shreg;
   logic [ADDR_W-1:0] shift_next;
   logic [ADDR_W-1:0] addr_next;
   logic              reload;
   logic              err_set;

   // The shift is resolved first so a latch in the same clock commits the
   // post-shift value.
   assign shift_next = shift_ev_p1 ? {dat_p1, shreg[ADDR_W-1:1]} : shreg;

   // One address-change event per clock; lower-priority events are dropped.
   // An out-of-range latch still consumes the slot but leaves the address.
   always_comb begin
      addr_next = sel_addr;
      reload    = 1'b0;
      err_set   = 1'b0;
      if (rst_ev_p1) begin
         addr_next = '0;
         reload    = 1'b1;
      end else if (latch_ev_p1) begin
         if ({1'b0, shift_next} < NUM_EXT) begin
            addr_next = shift_next;
            reload    = 1'b1;
         end else begin
            err_set   = 1'b1;
         end
      end else if (inc_ev_p1) begin
         addr_next = wrap_inc(sel_addr);
         reload    = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= DRST;
         cnt          <= CNT_LOAD;
         shreg        <= '0;
         sel_addr     <= '0;
         sel_ena      <= 1'b0;
         design_rst_n <= 1'b0;
         busy         <= 1'b1;
         load_err     <= 1'b0;
      end else begin
         shreg    <= shift_next;
         sel_addr <= addr_next;
         if (err_set) load_err <= 1'b1;

         if (reload) begin
            state        <= DRST;
            cnt          <= CNT_LOAD;
            sel_ena      <= 1'b0;
            design_rst_n <= 1'b0;
            busy         <= 1'b1;
         end else begin
            unique case (state)
               DRST: begin
                  if (cnt == '0) begin
                     state        <= ACTIVE;
                     design_rst_n <= 1'b1;
                     busy         <= 1'b0;
                     sel_ena      <= 1'b0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ACTIVE: begin
                  sel_ena <= lvl[P_ENA];
               end
               default: state <= DRST;
            endcase
         end
      end
   end

endmodule
